// File: rtl/instr_register_alu.sv
// rtl/instr_register_alu.sv - DEPTH-entry instruction store with a two-stage pipelined read/ALU port.
// Build with INSTR_REG_DIVIDE_EN defined to include the signed divider for DIV/MOD.
module instr_register_alu #(
  parameter int DEPTH = 32,
  parameter int OPW   = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [AW-1:0]         write_pointer,
  input  logic [2:0]            opcode,
  input  logic signed [OPW-1:0] operand_a,
  input  logic signed [OPW-1:0] operand_b,
  input  logic                  rd_en,
  input  logic [AW-1:0]         read_pointer,
  output logic                  rd_valid,
  output logic [2:0]            rd_opcode,
  output logic signed [OPW-1:0] rd_operand_a,
  output logic signed [OPW-1:0] rd_operand_b,
  output logic signed [2*OPW-1:0] rd_result,
  output logic                  rd_err,
  output logic [AW:0]           entries_used
);

  typedef enum logic [2:0] {
    OP_ZERO  = 3'd0,
    OP_PASSA = 3'd1,
    OP_PASSB = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_MULT  = 3'd5,
    OP_DIV   = 3'd6,
    OP_MOD   = 3'd7
  } opcode_t;

  logic [2:0]     opc_mem_q [DEPTH];
  logic [OPW-1:0] a_mem_q   [DEPTH];
  logic [OPW-1:0] b_mem_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW:0]      entries_used_q;

  logic           s0_valid_q;
  logic           s0_hit_q;
  logic [2:0]     s0_opc_q;
  logic [OPW-1:0] s0_a_q;
  logic [OPW-1:0] s0_b_q;

  logic                   rd_valid_q;
  logic [2:0]             rd_opc_q;
  logic [OPW-1:0]         rd_a_q;
  logic [OPW-1:0]         rd_b_q;
  logic [2*OPW-1:0]       rd_result_q;
  logic                   rd_err_q;

  logic                   bypass;
  logic signed [2*OPW-1:0] ext_a;
  logic signed [2*OPW-1:0] ext_b;
  logic signed [2*OPW-1:0] result_d;
  logic                   err_d;

  // Storage is deliberately left out of reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (load_en) begin
      opc_mem_q[write_pointer] <= opcode;
      a_mem_q[write_pointer]   <= operand_a;
      b_mem_q[write_pointer]   <= operand_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= '0;
      entries_used_q <= '0;
    end else if (load_en) begin
      valid_q[write_pointer] <= 1'b1;
      if (!valid_q[write_pointer]) begin
        entries_used_q <= entries_used_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  assign bypass = load_en && (write_pointer == read_pointer);

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
    end else begin
      s0_valid_q <= rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      s0_hit_q <= bypass ? 1'b1      : valid_q[read_pointer];
      s0_opc_q <= bypass ? opcode    : opc_mem_q[read_pointer];
      s0_a_q   <= bypass ? operand_a : a_mem_q[read_pointer];
      s0_b_q   <= bypass ? operand_b : b_mem_q[read_pointer];
    end
  end

  // Widening first makes every result, including the full product, exact.
  always_comb begin
    ext_a    = {{OPW{s0_a_q[OPW-1]}}, s0_a_q};
    ext_b    = {{OPW{s0_b_q[OPW-1]}}, s0_b_q};
    result_d = '0;
    err_d    = 1'b0;
    if (!s0_hit_q) begin
      err_d = 1'b1;
    end else begin
      case (opcode_t'(s0_opc_q))
        OP_ZERO:  result_d = '0;
        OP_PASSA: result_d = ext_a;
        OP_PASSB: result_d = ext_b;
        OP_ADD:   result_d = ext_a + ext_b;
        OP_SUB:   result_d = ext_a - ext_b;
        OP_MULT:  result_d = ext_a * ext_b;
`ifdef INSTR_REG_DIVIDE_EN
        OP_DIV: begin
          if (ext_b == '0) err_d = 1'b1;
          else             result_d = ext_a / ext_b;
        end
        OP_MOD: begin
          if (ext_b == '0) err_d = 1'b1;
          else             result_d = ext_a % ext_b;
        end
`else
        OP_DIV, OP_MOD: err_d = 1'b1;
`endif
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !s0_valid_q) begin
      rd_valid_q  <= 1'b0;
      rd_opc_q    <= '0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      rd_result_q <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      rd_valid_q  <= 1'b1;
      rd_opc_q    <= s0_opc_q;
      rd_a_q      <= s0_a_q;
      rd_b_q      <= s0_b_q;
      rd_result_q <= result_d;
      rd_err_q    <= err_d;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_opcode    = rd_opc_q;
  assign rd_operand_a = rd_a_q;
  assign rd_operand_b = rd_b_q;
  assign rd_result    = rd_result_q;
  assign rd_err       = rd_err_q;
  assign entries_used = entries_used_q;

endmodule

// File: tb/tb_instr_register_alu.sv
// tb/tb_instr_register_alu.sv - scoreboard bench for instr_register_alu.
module tb_instr_register_alu;

  localparam logic [2:0] OP_ZERO = 3'd0, OP_PASSA = 3'd1, OP_PASSB = 3'd2, OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4, OP_MULT = 3'd5, OP_DIV = 3'd6, OP_MOD = 3'd7;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_en;
  logic [4:0]         write_pointer;
  logic [2:0]         opcode;
  logic signed [31:0] operand_a;
  logic signed [31:0] operand_b;
  logic               rd_en;
  logic [4:0]         read_pointer;
  logic               rd_valid;
  logic [2:0]         rd_opcode;
  logic signed [31:0] rd_operand_a;
  logic signed [31:0] rd_operand_b;
  logic signed [63:0] rd_result;
  logic               rd_err;
  logic [5:0]         entries_used;

  instr_register_alu dut (
    .clk(clk), .reset(reset), .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .rd_en(rd_en), .read_pointer(read_pointer), .rd_valid(rd_valid),
    .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
    .rd_result(rd_result), .rd_err(rd_err), .entries_used(entries_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    bit                 chk_data;
    logic [2:0]         opc;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [63:0] res;
    bit                 err;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  bit                 mv [32];
  logic [2:0]         mo [32];
  logic signed [31:0] ma [32];
  logic signed [31:0] mb [32];
  int                 used;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic void calc(input logic [2:0] op, input logic signed [31:0] a,
                               input logic signed [31:0] b,
                               output logic signed [63:0] r, output bit er);
    longint la, lb;
    la = a;
    lb = b;
    r  = 0;
    er = 1'b0;
    case (op)
      OP_ZERO:  r = 0;
      OP_PASSA: r = la;
      OP_PASSB: r = lb;
      OP_ADD:   r = la + lb;
      OP_SUB:   r = la - lb;
      OP_MULT:  r = la * lb;
`ifdef INSTR_REG_DIVIDE_EN
      OP_DIV: if (lb == 0) er = 1'b1; else r = la / lb;
      OP_MOD: if (lb == 0) er = 1'b1; else r = la % lb;
`else
      OP_DIV, OP_MOD: er = 1'b1;
`endif
      default: r = 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 64'(rd_valid), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("latency", 64'(cyc), 64'(e.cyc + 2));
          check("rd_err", 64'(rd_err), 64'(e.err));
          check("rd_result", rd_result, e.res);
          if (e.chk_data) begin
            check("rd_opcode", 64'(rd_opcode), 64'(e.opc));
            check("rd_operand_a", 64'(rd_operand_a), 64'(e.a));
            check("rd_operand_b", 64'(rd_operand_b), 64'(e.b));
          end
        end
      end else begin
        check("idle_outputs_zero",
              64'(|{rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err}), 64'd0);
        if (q.size() > 0 && q[0].cyc + 2 <= cyc) begin
          check("missing_valid", 64'(rd_valid), 64'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit ld, input int wp, input logic [2:0] op,
                      input logic signed [31:0] a, input logic signed [31:0] b,
                      input bit rd, input int rp);
    exp_t e;
    bit   byp;
    load_en       = ld;
    write_pointer = wp[4:0];
    opcode        = op;
    operand_a     = a;
    operand_b     = b;
    rd_en         = rd;
    read_pointer  = rp[4:0];
    if (rd) begin
      byp        = ld && (wp == rp);
      e.cyc      = cyc;
      e.chk_data = byp || mv[rp];
      e.opc      = byp ? op : mo[rp];
      e.a        = byp ? a : ma[rp];
      e.b        = byp ? b : mb[rp];
      if (e.chk_data) calc(e.opc, e.a, e.b, e.res, e.err);
      else begin
        e.res = 0;
        e.err = 1'b1;
      end
      q.push_back(e);
    end
    if (ld) begin
      if (!mv[wp]) used++;
      mv[wp] = 1'b1;
      mo[wp] = op;
      ma[wp] = a;
      mb[wp] = b;
    end
    @(posedge clk);
    #1;
    load_en = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic wr(input int wp, input logic [2:0] op, input logic signed [31:0] a,
                    input logic signed [31:0] b);
    step(1'b1, wp, op, a, b, 1'b0, 0);
  endtask

  task automatic rd(input int rp);
    step(1'b0, 0, OP_ZERO, 0, 0, 1'b1, rp);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, OP_ZERO, 0, 0, 1'b0, 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    used = 0;
    q.delete();
  endtask

  initial begin
    logic signed [31:0] ra, rb;
    logic [2:0]         rop;
    reset = 1'b1;
    load_en = 1'b0; write_pointer = '0; opcode = '0; operand_a = '0; operand_b = '0;
    rd_en = 1'b0; read_pointer = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    check("entries_used_reset", 64'(entries_used), 64'(used));

    rd(5);
    idle(2);

    wr(3, OP_ADD, -15, 7);
    check("entries_used_one", 64'(entries_used), 64'(used));
    rd(3);
    wr(4, OP_MULT, 32'sh8000_0000, 32'sh8000_0000);
    rd(4);
    idle(2);

    wr(6, OP_DIV, -7, 2);
    wr(7, OP_MOD, -7, 2);
    wr(8, OP_DIV, 5, 0);
    wr(9, OP_DIV, 32'sh8000_0000, -1);
    wr(10, OP_MOD, 7, -2);
    wr(11, OP_MOD, 9, 0);
    for (int i = 6; i <= 11; i++) rd(i);
    idle(2);

    step(1'b1, 31, OP_SUB, 10, 3, 1'b1, 31);
    check("entries_used_after_31", 64'(entries_used), 64'(used));
    wr(31, OP_PASSA, 123, -4);
    check("entries_used_rewrite", 64'(entries_used), 64'(used));
    rd(31);
    idle(2);

    for (int i = 0; i < 32; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'sd0 : 32'($urandom);
      wr(i, rop, ra, rb);
    end
    check("entries_used_full", 64'(entries_used), 64'd32);

    for (int i = 0; i < 32; i++) rd(i);
    idle(3);

    for (int i = 0; i < 9; i++) rd(i);
    reset         = 1'b1;
    rd_en         = 1'b1;
    read_pointer  = 5'd9;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_en = 1'b0;
    clear_model();
    check("entries_used_midreset", 64'(entries_used), 64'(used));
    idle(2);
    for (int i = 0; i < 4; i++) rd(i);
    idle(3);

    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_register_alu.md
Name: instr_register_alu

Overview:
- Parametrised successor to the instruction register: DEPTH-entry store of {opcode, operand_a, operand_b} words with per-entry valid bits.
- Adds a fully pipelined read port that returns the stored instruction and its computed result two cycles after the read request.
- Sits between the testbench/stimulus interface and the downstream scoreboard, which consumes rd_result/rd_err directly.

Parameters:
- DEPTH, 32, number of instruction entries (power of 2, >=2)
- OPW, 32, signed operand width in bits
- AW, $clog2(DEPTH), pointer width (derived; not overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load_en  in  1  write strobe
- write_pointer  in  AW  write address
- opcode  in  3  opcode_t: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7
- operand_a  in  OPW  signed
- operand_b  in  OPW  signed
- rd_en  in  1  read request
- read_pointer  in  AW  read address
- rd_valid  out  1  read response valid
- rd_opcode  out  3  stored opcode
- rd_operand_a  out  OPW  stored operand_a
- rd_operand_b  out  OPW  stored operand_b
- rd_result  out  2*OPW  signed computed result
- rd_err  out  1  entry unwritten, divide-by-zero, or opcode disabled
- entries_used  out  AW+1  count of valid entries

Behaviour:
- Reset (reset=1 at an edge): all valid bits, pipeline valids and all outputs cleared to 0 on that edge. Storage data is not cleared.
- Reset mid-stream: in-flight reads are dropped; rd_valid=0 from the cycle after the reset edge.
- Write: when load_en=1, the entry at write_pointer is written and its valid bit set on the edge.
  - entries_used increments only when the entry was previously invalid.
  - Overwriting a valid entry leaves entries_used unchanged.
  - entries_used saturates naturally at DEPTH.
- Read pipeline, fully pipelined, one request per cycle:
  - S0: rd_en sampled at edge N; entry and valid bit captured.
  - S1: result computed; outputs registered at edge N+1.
  - rd_valid=1 during the cycle following edge N+1, i.e. two cycles after rd_en was presented.
- Write-first bypass: if load_en and rd_en are both 1 with write_pointer==read_pointer in the same cycle, the read returns the newly written data with rd_err=0 (unless the result itself sets rd_err).
- When rd_valid=0, the rd_* outputs hold 0.
- Unwritten entry: rd_err=1, rd_result=0; rd_opcode/operands report the stored (possibly stale) contents.
- Arithmetic: operands are sign-extended to 2*OPW before the operation; no overflow is possible.
  - ZERO: 0
  - PASSA: a
  - PASSB: b
  - ADD: a+b
  - SUB: a-b
  - MULT: full signed product
  - DIV: signed, truncating toward zero
  - MOD: remainder with the sign of the dividend
  - DIV/MOD with b==0: rd_result=0, rd_err=1
  - -2^(OPW-1) / -1 = +2^(OPW-1), no error
- Pointers are AW bits wide, so out-of-range addresses cannot occur.

Optional Feature:
- Macro INSTR_REG_DIVIDE_EN.
- Defined: DIV and MOD are implemented exactly as above.
- Undefined: no divider is synthesised; DIV and MOD return rd_result=0 with rd_err=1 for every operand value. All other opcodes are unaffected.

Test Plan:
- Reset held 2 cycles, then rd_en for address 5 -> two cycles later rd_valid=1, rd_err=1, rd_result=0; entries_used=0.
- Write address 3: ADD, a=-15, b=7; read address 3 -> rd_opcode=3, rd_result=-8, rd_err=0; entries_used=1. Write MULT a=-2^31, b=-2^31 to address 4; read -> rd_result=2^62.
- Macro defined: DIV a=-7, b=2 -> -3; MOD a=-7, b=2 -> -1; DIV a=5, b=0 -> rd_result=0, rd_err=1. Macro undefined: DIV a=-7, b=2 -> rd_result=0, rd_err=1.
- Same-cycle write and read of address 31 (SUB, a=10, b=3) -> rd_result=7, rd_err=0. Rewriting address 31 -> entries_used unchanged. Writing all 32 addresses -> entries_used=32.
- Back-to-back reads of addresses 0..31 on consecutive cycles -> rd_valid high for 32 consecutive cycles, in order. Reset asserted on the 10th read -> rd_valid=0 from the next cycle, entries_used=0, and subsequent reads return rd_err=1.
